// File: rtl/alu_ctrl_pkg.sv
// ALU control codes and execute-stage FSM encoding.
// Shared between the ALU controller and the execute unit.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRLV = 4'b0100;
   localparam logic [3:0] ALU_JR   = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_MUL  = 4'b1000;
   localparam logic [3:0] ALU_LUI  = 4'b1001;
   localparam logic [3:0] ALU_ORI  = 4'b1010;
   localparam logic [3:0] ALU_JAL  = 4'b1110;
   localparam logic [3:0] ALU_BGEZ = 4'b1111;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Sequencing (start/run) is owned by the caller's FSM.
module mul_iter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start,
   input  logic              run,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] prod
);

   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] acc_nxt;

   assign acc_nxt = b_q[0] ? acc_q + a_q : acc_q;
   assign done    = run && (cnt_q == CNT_W'(DATA_W - 1));
   assign prod    = acc_nxt;

   // latch operands on start, then add one shifted multiplicand per cycle
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         a_q   <= a;
         b_q   <= b;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (run) begin
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle ops plus an iterative multiply.
// ready_o drops while a multiply is iterating.
module alu_exec_unit
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [3:0]        ALUCtrl_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   input  logic [4:0]        shamt_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o,
   output logic              sign_o,
   output logic              valid_o
);

   state_t            state_q;
   logic              sign_q;
   logic              accept;
   logic              mul_start;
   logic              mul_run;
   logic              mul_done;
   logic [DATA_W-1:0] mul_prod;
   logic [DATA_W-1:0] op_res;
   logic              lt;

   assign ready_o   = (state_q == S_IDLE);
   assign accept    = valid_i && ready_o && !flush_i;
   assign mul_start = accept && (ALUCtrl_i == ALU_MUL);
   assign mul_run   = (state_q == S_MUL) && !flush_i;
   assign lt        = $signed(src1_i) < $signed(src2_i);

   mul_iter #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_mul (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .start (mul_start),
      .run   (mul_run),
      .a     (src1_i),
      .b     (src2_i),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   // single-cycle operation mux; unknown codes yield zero
   always_comb begin
      op_res = '0;
      unique case (ALUCtrl_i)
         ALU_AND:  op_res = src1_i & src2_i;
         ALU_OR:   op_res = src1_i | src2_i;
         ALU_ADD:  op_res = src1_i + src2_i;
         ALU_SUB:  op_res = src1_i - src2_i;
         ALU_SLT:  op_res = {{(DATA_W-1){1'b0}}, lt};
         ALU_SLL:  op_res = src2_i << shamt_i;
         ALU_SRLV: op_res = src2_i >> src1_i[4:0];
         ALU_JR:   op_res = src1_i;
         ALU_LUI:  op_res = src2_i << 16;
         ALU_ORI:  op_res = src1_i | {{(DATA_W-16){1'b0}}, src2_i[15:0]};
         ALU_BGEZ: op_res = src1_i;
         ALU_JAL:  op_res = src2_i;
         default:  op_res = '0;
      endcase
   end

   // handshake FSM and registered result/flags
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= S_IDLE;
         result_o <= '0;
         zero_o   <= 1'b1;
         sign_o   <= 1'b0;
         sign_q   <= 1'b0;
         valid_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (flush_i) begin
            state_q <= S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (mul_start) begin
                     state_q <= S_MUL;
                     sign_q  <= src1_i[DATA_W-1];
                  end else if (accept) begin
                     result_o <= op_res;
                     zero_o   <= (op_res == '0);
                     sign_o   <= src1_i[DATA_W-1];
                     valid_o  <= 1'b1;
                  end
               end
               S_MUL: begin
                  if (mul_done) begin
                     state_q  <= S_IDLE;
                     result_o <= mul_prod;
                     zero_o   <= (mul_prod == '0);
                     sign_o   <= sign_q;
                     valid_o  <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule
